// File: rtl/det_event_fifo.sv
// det_event_fifo: logs seq_det detections as bit-index timestamps
// in a small FWFT FIFO, with match/drop counters and overflow flag.
module det_event_fifo #(
    parameter int DEPTH = 4,
    parameter int TS_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr_i,
    input  logic                       en_i,
    input  logic                       detect_i,
    output logic [TS_W-1:0]            evt_data_o,
    output logic                       evt_valid_o,
    input  logic                       evt_ready_i,
    output logic [CNT_W-1:0]           evt_count_o,
    output logic [CNT_W-1:0]           drop_count_o,
    output logic                       overflow_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0]      PTR_ONE = (AW+1)'(1);
    localparam logic [TS_W-1:0]  TS_ONE  = TS_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [TS_W-1:0]  mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [TS_W-1:0]  ts;
    logic [CNT_W-1:0] evt_cnt;
    logic [CNT_W-1:0] drop_cnt;
    logic             ovf;
    logic [AW:0]      level;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic wr;
    logic drop;

    // Full/empty come from the pointer wrap bit, so all DEPTH slots are usable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign push = en_i & detect_i;
    assign pop  = !empty & evt_ready_i;
    // A push into a full FIFO still lands if the head leaves in the same cycle.
    assign wr   = push & (!full | pop);
    assign drop = push & full & !pop;

    assign evt_valid_o  = !empty;
    assign evt_data_o   = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign evt_count_o  = evt_cnt;
    assign drop_count_o = drop_cnt;
    assign overflow_o   = ovf;
    assign level_o      = level;

    // Timestamp counter, FIFO storage/pointers, occupancy and event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ts       <= '0;
            evt_cnt  <= '0;
            drop_cnt <= '0;
            ovf      <= 1'b0;
            level    <= '0;
        end else if (clr_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ts       <= '0;
            evt_cnt  <= '0;
            drop_cnt <= '0;
            ovf      <= 1'b0;
            level    <= '0;
        end else begin
            if (en_i) begin
                ts <= ts + TS_ONE;
            end
            if (wr) begin
                mem[wr_ptr[AW-1:0]] <= ts;
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (wr && !pop) begin
                level <= level + PTR_ONE;
            end else if (pop && !wr) begin
                level <= level - PTR_ONE;
            end
            if (push && evt_cnt != CNT_MAX) begin
                evt_cnt <= evt_cnt + CNT_ONE;
            end
            if (drop) begin
                ovf <= 1'b1;
                if (drop_cnt != CNT_MAX) begin
                    drop_cnt <= drop_cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_det_event_fifo.sv
// tb_det_event_fifo: directed stimulus with a timestamp scoreboard
// checked by an independent monitor on the read side.
module tb_det_event_fifo;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        en;
    logic        det;
    logic        rdy;
    logic [7:0]  data;
    logic        valid;
    logic [15:0] evt_count;
    logic [15:0] drop_count;
    logic        ovf;
    logic [2:0]  level;

    logic        s_clr;
    logic        s_en;
    logic        s_det;
    logic        s_rdy;
    logic [7:0]  s_data;
    logic        s_valid;
    logic [1:0]  s_evt;
    logic [1:0]  s_drop;
    logic        s_ovf;
    logic [1:0]  s_level;

    int checks = 0;
    int fails  = 0;
    logic [7:0] expq [$];

    det_event_fifo dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (clr),
        .en_i         (en),
        .detect_i     (det),
        .evt_data_o   (data),
        .evt_valid_o  (valid),
        .evt_ready_i  (rdy),
        .evt_count_o  (evt_count),
        .drop_count_o (drop_count),
        .overflow_o   (ovf),
        .level_o      (level)
    );

    det_event_fifo #(.DEPTH(2), .TS_W(8), .CNT_W(2)) u_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (s_clr),
        .en_i         (s_en),
        .detect_i     (s_det),
        .evt_data_o   (s_data),
        .evt_valid_o  (s_valid),
        .evt_ready_i  (s_rdy),
        .evt_count_o  (s_evt),
        .drop_count_o (s_drop),
        .overflow_o   (s_ovf),
        .level_o      (s_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted head entry must match the scoreboard front.
    always @(negedge clk) begin
        if (rst_n && !clr && valid && rdy) begin
            checks++;
            if (expq.size() == 0) begin
                fails++;
                $display("FAIL pop_unexpected: got %0d, expected none", data);
            end else begin
                logic [7:0] e;
                e = expq.pop_front();
                if (data !== e) begin
                    fails++;
                    $display("FAIL pop_data: got %0d, expected %0d", data, e);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        clr = 0; en = 0; det = 0; rdy = 0;
        s_clr = 0; s_en = 0; s_det = 0; s_rdy = 0;
        repeat (5) step();
        rst_n = 1'b1;
        step();
        check("rst_valid", 32'(valid), 0);
        check("rst_level", 32'(level), 0);
        check("rst_evt_count", 32'(evt_count), 0);
        check("rst_drop_count", 32'(drop_count), 0);
        check("rst_overflow", 32'(ovf), 0);
        check("rst_data", 32'(data), 0);

        // Stream, reader always ready: detects at ts=3 and ts=6.
        rdy = 1; en = 1;
        for (int i = 0; i < 8; i++) begin
            det = (i == 3 || i == 6);
            if (det) expq.push_back(8'(i));
            step();
            check($sformatf("stream_valid_%0d", i), 32'(valid),
                  32'(i == 3 || i == 6));
        end
        en = 0; det = 0;
        step();
        check("stream_evt_count", 32'(evt_count), 2);

        // Gating: detect without en is ignored, ts stays at 8.
        det = 1;
        repeat (3) step();
        check("gate_evt_count", 32'(evt_count), 2);
        check("gate_level", 32'(level), 0);
        en = 1;
        expq.push_back(8'd8);
        step();
        en = 0; det = 0;
        step();
        check("gate_evt_count2", 32'(evt_count), 3);

        // Clear, then overflow with reader stalled: ts 0..5.
        clr = 1;
        step();
        clr = 0;
        check("clr_evt_count", 32'(evt_count), 0);
        rdy = 0; en = 1; det = 1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) expq.push_back(8'(i));
            step();
        end
        det = 0;
        en = 0;
        check("ovf_level", 32'(level), 4);
        check("ovf_drop_count", 32'(drop_count), 2);
        check("ovf_flag", 32'(ovf), 1);
        check("ovf_evt_count", 32'(evt_count), 6);
        check("ovf_head", 32'(data), 0);

        // Full with simultaneous push/pop at ts=9.
        en = 1;
        repeat (3) step();
        det = 1; rdy = 1;
        expq.push_back(8'd9);
        step();
        det = 0; en = 0;
        check("fullpp_level", 32'(level), 4);
        check("fullpp_drop", 32'(drop_count), 2);
        begin
            int n;
            n = 0;
            while (valid && n < 20) begin
                step();
                n++;
            end
        end
        check("drain_level", 32'(level), 0);
        check("drain_valid", 32'(valid), 0);

        // Clear wins over a concurrent push.
        clr = 1; en = 1; det = 1;
        step();
        clr = 0;
        check("clr_overflow", 32'(ovf), 0);
        check("clr_drop_count", 32'(drop_count), 0);
        check("clr_push_evt", 32'(evt_count), 0);
        check("clr_push_level", 32'(level), 0);
        expq.push_back(8'd0);
        step();
        en = 0; det = 0;
        step();
        check("post_clr_evt", 32'(evt_count), 1);

        // Timestamp wrap: detect on en cycle 257 logs ts=1.
        clr = 1;
        step();
        clr = 0;
        en = 1;
        for (int i = 0; i < 260; i++) begin
            det = (i == 257);
            if (det) expq.push_back(8'd1);
            step();
        end
        en = 0; det = 0;
        step();
        check("wrap_evt_count", 32'(evt_count), 1);

        // Saturation on the narrow-counter instance.
        s_en = 1; s_det = 1;
        repeat (5) step();
        s_en = 0; s_det = 0;
        step();
        check("sat_evt_count", 32'(s_evt), 3);
        check("sat_drop_count", 32'(s_drop), 3);
        check("sat_overflow", 32'(s_ovf), 1);
        check("sat_level", 32'(s_level), 2);

        // Mid-stream async reset with stalled reader.
        rdy = 0; en = 1; det = 1;
        repeat (3) step();
        #3;
        rst_n = 0;
        #1;
        check("midrst_level", 32'(level), 0);
        check("midrst_valid", 32'(valid), 0);
        check("midrst_evt", 32'(evt_count), 0);
        check("midrst_sat_evt", 32'(s_evt), 0);
        expq.delete();
        en = 0; det = 0;
        step();
        step();
        rst_n = 1;
        rdy = 1; en = 1; det = 1;
        expq.push_back(8'd0);
        step();
        en = 0; det = 0;
        repeat (3) step();
        check("scoreboard_empty", 32'(expq.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/det_event_fifo.md
Name: det_event_fifo

Overview:
- Downstream consumer of seq_det: takes its single-cycle detect pulse and logs each detection with a bit-index timestamp.
- Timestamps go into a small first-word-fall-through FIFO, drained by a valid/ready reader, so software or a later stage can recover where each match occurred.
- Also keeps a saturating total-match counter, a saturating dropped-event counter and a sticky overflow flag.

Parameters:
- DEPTH, 4, FIFO entries; must be a power of two, at least 2.
- TS_W, 8, timestamp width in bits; the bit-index counter wraps modulo 2^TS_W.
- CNT_W, 16, width of evt_count_o and drop_count_o.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr_i  input  1  synchronous clear of all state; has priority over every other input.
- en_i  input  1  bit strobe: high in each cycle where seq_det consumed one data_i bit.
- detect_i  input  1  detect_o from seq_det; counted only when en_i=1.
- evt_data_o  output  TS_W  timestamp at the FIFO head.
- evt_valid_o  output  1  FIFO not empty.
- evt_ready_i  input  1  reader accepts the head entry.
- evt_count_o  output  CNT_W  total detections seen, saturating.
- drop_count_o  output  CNT_W  detections lost to a full FIFO, saturating.
- overflow_o  output  1  sticky; set on the first dropped event.
- level_o  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n=0, async) and clr_i=1 (sync) clear everything: ts counter, read/write pointers, evt_count_o, drop_count_o, overflow_o, level_o and evt_valid_o all go to 0; evt_data_o reads 0.
- Timestamp counter ts: increments by 1 on each clk where en_i=1, and wraps from 2^TS_W-1 to 0.
- Push: push = en_i & detect_i. The value written is the current ts, i.e. the value before that cycle's increment. detect_i with en_i=0 is ignored entirely.
- Pop: pop = evt_valid_o & evt_ready_i. evt_ready_i while empty is a no-op.
- FIFO is first-word-fall-through: evt_data_o is the head entry whenever evt_valid_o=1.
  - Push into an empty FIFO: evt_valid_o rises the next cycle (latency 1). There is no same-cycle bypass.
  - evt_data_o is don't-care while evt_valid_o=0; it must be 0 after reset.
- Full with push and pop in the same cycle: both take effect, level unchanged, no drop.
- Full with push and no pop: the event is dropped and the FIFO contents are unchanged.
  - drop_count_o increments, saturating at 2^CNT_W-1.
  - overflow_o is set and stays set until reset or clr_i.
- Empty with push and pop in the same cycle: the pop is invalid because evt_valid_o=0, so only the push happens.
- evt_count_o increments on every push, including dropped ones, and saturates at 2^CNT_W-1 with no wrap.
- level_o equals the number of valid entries, 0..DEPTH. Pointers are $clog2(DEPTH) bits and full/empty use an extra wrap bit.
- clr_i asserted together with push/pop: the clear wins and the push is discarded. The next cycle starts at ts=0.
- Reset mid-stream: all state is lost immediately with no partial writes. Outputs hold their reset values until rst_n deasserts, and the first en_i after release carries timestamp 0.
- All outputs are registered except evt_data_o/evt_valid_o, which are decoded from registered pointers and memory. None is combinational from any input.

Test Plan:
- Reset values: hold rst_n=0 for 5 cycles, then release -> evt_valid_o=0, level_o=0, evt_count_o=0, drop_count_o=0, overflow_o=0.
- Stream with reader always ready: en_i=1 every cycle; drive detect_i=1 in the cycles with ts=3 and ts=6, mimicking detection of 1011 at bits 3 and 6 -> evt_valid_o pulses in the cycles after ts=3 and after ts=6 with evt_data_o=3 then 6; evt_count_o=2.
- Gating: detect_i=1 with en_i=0 for 3 cycles -> evt_count_o, level_o and ts all unchanged.
- Overflow with evt_ready_i=0: 6 detections at ts=0..5 -> level_o=4, drop_count_o=2, overflow_o=1, then drain reads 0,1,2,3. Assert clr_i -> overflow_o=0, drop_count_o=0, evt_count_o=0.
- Full simultaneous push/pop: FIFO full, evt_ready_i=1 and detect at ts=9 -> level_o stays 4, drop_count_o unchanged, and 9 appears after the three older entries.
- Wrap: 260 en_i cycles with a detect at cycle 257 -> logged timestamp=1; saturation test with CNT_W=2 and 5 detections -> evt_count_o=3.
